// File: rtl/addsub_share_arbiter.sv
`default_nettype none
// addsub_share_arbiter (rev 1.0): round-robin share of one external ripple add/sub between two requesters.
// Optional build macro ADDSUB_STATS_EN adds saturating completed/overflow job counters.
module addsub_share_arbiter #(
  parameter int WIDTH         = 6,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic [WIDTH-1:0] add_x,
  output logic [WIDTH-1:0] add_y,
  output logic             add_sel,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_overflow,
  input  logic             add_cout,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_sum,
  output logic             resp_overflow,
  output logic             resp_cout,
  output logic [7:0]       stat_ops,
  output logic [7:0]       stat_ovf
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, RESP = 2'd2} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] add_x_q, add_x_d;
  logic [WIDTH-1:0] add_y_q, add_y_d;
  logic             add_sel_q, add_sel_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_sum_q, resp_sum_d;
  logic             resp_overflow_q, resp_overflow_d;
  logic             resp_cout_q, resp_cout_d;

  logic grant_id;
  logic accept;
  logic resp_hs;

  // With both valid, the requester not served last wins; otherwise whoever is valid.
  assign grant_id   = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
  assign req0_ready = rst_n && (state_q == IDLE) && req0_valid && !grant_id;
  assign req1_ready = rst_n && (state_q == IDLE) && req1_valid && grant_id;
  assign accept     = req0_ready || req1_ready;
  assign resp_hs    = resp_valid_q && resp_ready;

  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    owner_d         = owner_q;
    cnt_d           = cnt_q;
    add_x_d         = add_x_q;
    add_y_d         = add_y_q;
    add_sel_d       = add_sel_q;
    resp_valid_d    = resp_valid_q;
    resp_id_d       = resp_id_q;
    resp_sum_d      = resp_sum_q;
    resp_overflow_d = resp_overflow_q;
    resp_cout_d     = resp_cout_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          add_x_d      = grant_id ? req1_a : req0_a;
          add_y_d      = grant_id ? req1_b : req0_b;
          add_sel_d    = grant_id ? req1_sub : req0_sub;
          owner_d      = grant_id;
          last_grant_d = grant_id;
          cnt_d        = SETTLE_LOAD;
          state_d      = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) begin
          resp_sum_d      = add_sum;
          resp_overflow_d = add_overflow;
          resp_cout_d     = add_cout;
          resp_id_d       = owner_q;
          resp_valid_d    = 1'b1;
          state_d         = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_hs) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      last_grant_q    <= 1'b1;
      owner_q         <= 1'b0;
      cnt_q           <= 4'd0;
      add_x_q         <= '0;
      add_y_q         <= '0;
      add_sel_q       <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_id_q       <= 1'b0;
      resp_sum_q      <= '0;
      resp_overflow_q <= 1'b0;
      resp_cout_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      owner_q         <= owner_d;
      cnt_q           <= cnt_d;
      add_x_q         <= add_x_d;
      add_y_q         <= add_y_d;
      add_sel_q       <= add_sel_d;
      resp_valid_q    <= resp_valid_d;
      resp_id_q       <= resp_id_d;
      resp_sum_q      <= resp_sum_d;
      resp_overflow_q <= resp_overflow_d;
      resp_cout_q     <= resp_cout_d;
    end
  end

  assign add_x         = add_x_q;
  assign add_y         = add_y_q;
  assign add_sel       = add_sel_q;
  assign resp_valid    = resp_valid_q;
  assign resp_id       = resp_id_q;
  assign resp_sum      = resp_sum_q;
  assign resp_overflow = resp_overflow_q;
  assign resp_cout     = resp_cout_q;

`ifdef ADDSUB_STATS_EN
  logic [7:0] stat_ops_q, stat_ops_d;
  logic [7:0] stat_ovf_q, stat_ovf_d;

  always_comb begin
    stat_ops_d = stat_ops_q;
    stat_ovf_d = stat_ovf_q;
    if (resp_hs) begin
      if (stat_ops_q != 8'hFF) stat_ops_d = stat_ops_q + 8'd1;
      if (resp_overflow_q && (stat_ovf_q != 8'hFF)) stat_ovf_d = stat_ovf_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_ops_q <= 8'd0;
      stat_ovf_q <= 8'd0;
    end else begin
      stat_ops_q <= stat_ops_d;
      stat_ovf_q <= stat_ovf_d;
    end
  end

  assign stat_ops = stat_ops_q;
  assign stat_ovf = stat_ovf_q;
`else
  assign stat_ops = 8'd0;
  assign stat_ovf = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_addsub_share_arbiter.sv
`default_nettype none
// tb_addsub_share_arbiter: scoreboard bench with a 6-bit add/sub model attached to the adder port.
module tb_addsub_share_arbiter;

  localparam int W = 6;
`ifdef ADDSUB_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_sub = 1'b0, req1_sub = 1'b0;
  logic [W-1:0] add_x, add_y, add_sum;
  logic         add_sel, add_overflow, add_cout;
  logic         resp_valid, resp_id, resp_overflow, resp_cout;
  logic         resp_ready = 1'b1;
  logic [W-1:0] resp_sum;
  logic [7:0]   stat_ops, stat_ovf;

  addsub_share_arbiter #(.WIDTH(W), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .add_x(add_x), .add_y(add_y), .add_sel(add_sel),
    .add_sum(add_sum), .add_overflow(add_overflow), .add_cout(add_cout),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_sum(resp_sum), .resp_overflow(resp_overflow), .resp_cout(resp_cout),
    .stat_ops(stat_ops), .stat_ovf(stat_ovf)
  );

  // Attached adder/subtractor: y inverted and carry-in set for subtraction.
  logic [W-1:0] yb;
  assign yb = add_y ^ {W{add_sel}};
  assign {add_cout, add_sum} = {1'b0, add_x} + {1'b0, yb} + {{W{1'b0}}, add_sel};
  assign add_overflow = (add_x[W-1] == yb[W-1]) && (add_sum[W-1] != add_x[W-1]);

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic         id;
    logic [W-1:0] sum;
    logic         ovf;
    logic         cout;
    int           acc;
  } exp_t;

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    int ua, ub, sa, sb, r, sr;
    ua = int'(a); ub = int'(b);
    sa = (ua >= 32) ? ua - 64 : ua;
    sb = (ub >= 32) ? ub - 64 : ub;
    if (!s) begin
      r = ua + ub; sr = sa + sb; e.cout = (r > 63);
    end else begin
      r = ua - ub; sr = sa - sb; e.cout = (ua >= ub);
    end
    e.sum = W'(((r % 64) + 64) % 64);
    e.ovf = (sr > 31) || (sr < -32);
    e.id  = id;
    e.acc = 0;
    return e;
  endfunction

  exp_t         exp_q[$];
  logic         grant_log[$];
  bit           busy = 0;
  logic         model_last = 1'b1;
  int           m_ops = 0, m_ovf = 0;
  logic         prev_rv = 1'b0, prev_rr = 1'b0;
  logic         prev_id, prev_ovf, prev_cout;
  logic [W-1:0] prev_sum;

  always @(negedge clk) begin : monitor
    exp_t e;
    logic g, e0, e1;
    if (!rst_n) begin
      chk("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
      exp_q.delete();
      grant_log.delete();
      busy = 0; model_last = 1'b1; m_ops = 0; m_ovf = 0; prev_rv = 1'b0;
    end else begin
      chk("stat_ops", {24'd0, stat_ops}, (STATS != 0) ? m_ops : 0);
      chk("stat_ovf", {24'd0, stat_ovf}, (STATS != 0) ? m_ovf : 0);
      if (!busy) begin
        g  = (req0_valid && req1_valid) ? ~model_last : req1_valid;
        e0 = req0_valid && !g;
        e1 = req1_valid && g;
        chk("grant", {30'd0, req0_ready, req1_ready}, {30'd0, e0, e1});
        if (e0 || e1) begin
          e = g ? model(1'b1, req1_a, req1_b, req1_sub) : model(1'b0, req0_a, req0_b, req0_sub);
          e.acc = cyc;
          exp_q.push_back(e);
          grant_log.push_back(g);
          model_last = g;
          busy = 1;
        end
      end else begin
        chk("busy_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
      end
      if (prev_rv && !prev_rr) begin
        chk("hold_valid", {31'd0, resp_valid}, 32'd1);
        chk("hold_data", {22'd0, resp_id, resp_sum, resp_overflow, resp_cout},
            {22'd0, prev_id, prev_sum, prev_ovf, prev_cout});
      end else if (resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_resp", {31'd0, resp_valid}, 32'd0);
        end else begin
          e = exp_q[0];
          chk("latency", cyc - e.acc, 32'd3);
          chk("resp_id", {31'd0, resp_id}, {31'd0, e.id});
          chk("resp_sum", {26'd0, resp_sum}, {26'd0, e.sum});
          chk("resp_ovf_cout", {30'd0, resp_overflow, resp_cout}, {30'd0, e.ovf, e.cout});
        end
      end
      if (resp_valid && resp_ready) begin
        busy = 0;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          if (m_ops < 255) m_ops++;
          if (e.ovf && m_ovf < 255) m_ovf++;
        end
      end
      prev_rv = resp_valid; prev_rr = resp_ready;
      prev_id = resp_id; prev_sum = resp_sum; prev_ovf = resp_overflow; prev_cout = resp_cout;
    end
  end

  bit rr_rand = 0;
  always @(posedge clk) begin
    if (rr_rand) begin
      #1 resp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int n = 0;
    bit done = 0;
    if (id == 0) begin req0_a = a; req0_b = b; req0_sub = s; req0_valid = 1'b1; end
    else         begin req1_a = a; req1_b = b; req1_sub = s; req1_valid = 1'b1; end
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      done = (id == 0) ? req0_ready : req1_ready;
    end
    chk("send_timeout", {31'd0, !done}, 32'd0);
    @(posedge clk);
    #1;
    if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    do begin @(negedge clk); n++; end
    while ((busy || exp_q.size() != 0 || resp_valid) && n < 300);
    chk("drain_timeout", {31'd0, n >= 300}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic rand_jobs(input int id, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      send(id, W'($urandom_range(0, 63)), W'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    int n;
    // Reset held with a pending request: nothing may be granted, all outputs cleared.
    req0_a = 6'b000001; req0_b = 6'b000000; req0_sub = 1'b0; req0_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_outputs", {add_x, add_y, add_sel, resp_valid, resp_id, resp_sum, resp_overflow, resp_cout},
          32'd0);
      chk("rst_stats", {16'd0, stat_ops, stat_ovf}, 32'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("first_idle_ready", {31'd0, req0_ready}, 32'd1);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    drain();
    chk("t2_result", {24'd0, resp_id, resp_sum, resp_overflow}, {24'd0, 1'b0, 6'b000001, 1'b0});

    send(1, 6'b011111, 6'b000001, 1'b0);
    drain();
    chk("t3_add_ovf", {24'd0, resp_id, resp_sum, resp_overflow}, {24'd0, 1'b1, 6'b100000, 1'b1});
    send(0, 6'b000101, 6'b000011, 1'b1);
    drain();
    chk("t3_sub", {24'd0, resp_id, resp_sum, resp_overflow}, {24'd0, 1'b0, 6'b000010, 1'b0});

    // Backpressure: response must hold and a waiting requester must stay blocked.
    resp_ready = 1'b0;
    send(0, 6'b101010, 6'b010101, 1'b0);
    req1_a = 6'd9; req1_b = 6'd4; req1_sub = 1'b1; req1_valid = 1'b1;
    n = 0;
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    chk("t5_resp_seen", {31'd0, resp_valid}, 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("t5_blocked", {29'd0, resp_valid, req0_ready, req1_ready}, 32'd4);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_back_to_idle", {30'd0, resp_valid, req1_ready}, 32'd1);
    @(posedge clk);
    #1 req1_valid = 1'b0;
    drain();
    chk("t5_req1_result", {25'd0, resp_id, resp_sum}, {25'd0, 1'b1, 6'd5});

    // Reset in the middle of SETTLE aborts the job.
    send(0, 6'd7, 6'd9, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t6_abort", {25'd0, resp_valid, add_x}, 32'd0);
    end
    send(1, 6'd2, 6'd3, 1'b0);
    drain();
    chk("t6_idle_after_abort", {25'd0, resp_id, resp_sum}, {25'd0, 1'b1, 6'd5});

    // Both requesters continuously valid: alternate starting with 0.
    do_reset();
    fork
      begin send(0, 6'd1, 6'd2, 1'b0); send(0, 6'd40, 6'd30, 1'b1); end
      begin send(1, 6'd63, 6'd1, 1'b0); send(1, 6'd0, 6'd1, 1'b1); end
    join
    drain();
    chk("t4_grant_count", grant_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      chk("t4_grant_order", {31'd0, grant_log[i]}, i % 2);

    // Random traffic with random response backpressure.
    rr_rand = 1;
    fork
      rand_jobs(0, 25);
      rand_jobs(1, 25);
    join
    rr_rand = 0;
    #1 resp_ready = 1'b1;
    drain();

`ifdef ADDSUB_STATS_EN
    do_reset();
    for (int i = 0; i < 300; i++) send(0, 6'b011111, 6'b000001, 1'b0);
    drain();
    chk("stat_ops_sat", {24'd0, stat_ops}, 32'd255);
    chk("stat_ovf_sat", {24'd0, stat_ovf}, 32'd255);
`else
    chk("stat_tied_zero", {16'd0, stat_ops, stat_ovf}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1);
  end

endmodule
`default_nettype wire
